// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 init sequencer: FSM encoding, SCCB constants
// and the software-reset detector.
package ov5640_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PWRUP = 4'd1,
    ST_RD    = 4'd2,
    ST_LATCH = 4'd3,
    ST_SEND  = 4'd4,
    ST_WAIT  = 4'd5,
    ST_SWDLY = 4'd6,
    ST_NEXT  = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERROR = 4'd9
  } seq_state_e;

  localparam logic [15:0] SWRST_REG_ADDR      = 16'h3008;
  localparam logic [7:0]  OV5640_SCCB_WR_ADDR = 8'h78;

  // Only a write that sets bit 7 of 0x3008 resets the sensor; other 0x3008 writes do not.
  function automatic logic is_swrst(input logic [15:0] reg_addr, input logic [7:0] data);
    return (reg_addr == SWRST_REG_ADDR) && data[7];
  endfunction

endpackage

// File: rtl/ov5640_init_sequencer_if.sv
// Request/response bus between the init sequencer and the SCCB write master.
interface ov5640_init_sequencer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_dev_addr;
  logic [15:0] wr_reg_addr;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        wr_nack;

  modport master (
    output wr_valid, wr_dev_addr, wr_reg_addr, wr_data,
    input  wr_ready, wr_done, wr_nack
  );

  modport slave (
    input  wr_valid, wr_dev_addr, wr_reg_addr, wr_data,
    output wr_ready, wr_done, wr_nack
  );
endinterface

// File: rtl/ov5640_init_sequencer_delay_cnt.sv
// Loadable cycle counter: after a load of N (N >= 1), expired is high on the Nth cycle,
// so a state that waits for expired lasts exactly N cycles.
module ov5640_delay_cnt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] cycles,
  output logic         expired
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] last_r;
  logic         run_r;

  // Count from 0 up to cycles-1 after each load, then stop
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      last_r <= '0;
      run_r  <= 1'b0;
    end else if (load) begin
      cnt_r  <= '0;
      last_r <= cycles - W'(1);
      run_r  <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == last_r) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + W'(1);
      end
    end
  end

  assign expired = run_r && (cnt_r == last_r);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init ROM and issues one SCCB write per entry, with power-up and
// software-reset settle delays and bounded NACK retries.
module ov5640_init_sequencer
  import ov5640_pkg::*;
#(
  parameter int         ADDR_WIDTH    = 8,
  parameter int         INIT_REG_NUM  = 252,
  parameter logic [7:0] SCCB_DEV_ADDR = OV5640_SCCB_WR_ADDR,
  parameter int         PWRUP_DLY_CYC = 1_000_000,
  parameter int         SWRST_DLY_CYC = 250_000,
  parameter int         MAX_RETRY     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  ov5640_init_sequencer_if.master sccb,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error,
  output logic [ADDR_WIDTH-1:0] err_index
);

  localparam int DLY_MAX = (PWRUP_DLY_CYC > SWRST_DLY_CYC) ? PWRUP_DLY_CYC : SWRST_DLY_CYC;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INIT_REG_NUM - 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [DLY_W-1:0]      PWRUP_CNT = DLY_W'(PWRUP_DLY_CYC);
  localparam logic [DLY_W-1:0]      SWRST_CNT = DLY_W'(SWRST_DLY_CYC);

  seq_state_e            state_r;
  logic [ADDR_WIDTH-1:0] rom_addr_r;
  logic                  wr_valid_r;
  logic [15:0]           wr_reg_addr_r;
  logic [7:0]            wr_data_r;
  logic                  busy_r;
  logic                  init_done_r;
  logic                  init_error_r;
  logic [ADDR_WIDTH-1:0] err_index_r;
  logic [RETRY_W-1:0]    retry_r;

  logic                  start_ok_s;
  logic                  swrst_s;
  logic                  dly_load_s;
  logic [DLY_W-1:0]      dly_val_s;
  logic                  dly_expired_s;

  // Delay counter load: power-up on an accepted start, settle on an acked soft reset
  always_comb begin
    start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
    swrst_s    = is_swrst(wr_reg_addr_r, wr_data_r);
    dly_load_s = start_ok_s ||
                 ((state_r == ST_WAIT) && sccb.wr_done && !sccb.wr_nack && swrst_s);
    if (start_ok_s) begin
      dly_val_s = PWRUP_CNT;
    end else begin
      dly_val_s = SWRST_CNT;
    end
  end

  ov5640_delay_cnt #(
    .W (DLY_W)
  ) u_delay_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (dly_load_s),
    .cycles  (dly_val_s),
    .expired (dly_expired_s)
  );

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      rom_addr_r    <= '0;
      wr_valid_r    <= 1'b0;
      wr_reg_addr_r <= 16'h0000;
      wr_data_r     <= 8'h00;
      busy_r        <= 1'b0;
      init_done_r   <= 1'b0;
      init_error_r  <= 1'b0;
      err_index_r   <= '0;
      retry_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_ok_s) begin
            rom_addr_r   <= '0;
            init_done_r  <= 1'b0;
            init_error_r <= 1'b0;
            retry_r      <= '0;
            busy_r       <= 1'b1;
            state_r      <= ST_PWRUP;
          end
        end
        ST_PWRUP: begin
          if (dly_expired_s) begin
            state_r <= ST_RD;
          end
        end
        ST_RD: begin
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          wr_reg_addr_r <= rom_q[23:8];
          wr_data_r     <= rom_q[7:0];
          wr_valid_r    <= 1'b1;
          state_r       <= ST_SEND;
        end
        ST_SEND: begin
          if (sccb.wr_ready) begin
            wr_valid_r <= 1'b0;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sccb.wr_done) begin
            if (sccb.wr_nack) begin
              if (retry_r < RETRY_LIM) begin
                retry_r    <= retry_r + RETRY_W'(1);
                wr_valid_r <= 1'b1;
                state_r    <= ST_SEND;
              end else begin
                err_index_r  <= rom_addr_r;
                init_error_r <= 1'b1;
                busy_r       <= 1'b0;
                state_r      <= ST_ERROR;
              end
            end else if (swrst_s) begin
              state_r <= ST_SWDLY;
            end else begin
              state_r <= ST_NEXT;
            end
          end
        end
        ST_SWDLY: begin
          if (dly_expired_s) begin
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          retry_r <= '0;
          if (rom_addr_r == LAST_ADDR) begin
            init_done_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            rom_addr_r <= rom_addr_r + ADDR_WIDTH'(1);
            state_r    <= ST_RD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr         = rom_addr_r;
  assign sccb.wr_valid    = wr_valid_r;
  assign sccb.wr_dev_addr = SCCB_DEV_ADDR;
  assign sccb.wr_reg_addr = wr_reg_addr_r;
  assign sccb.wr_data     = wr_data_r;
  assign busy             = busy_r;
  assign init_done        = init_done_r;
  assign init_error       = init_error_r;
  assign err_index        = err_index_r;

endmodule
